// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_DW = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ram_core.sv
// Synchronous single-port RAM: writes when we is high, otherwise registers mem[addr] to q.
module ram_core #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer placing two requesters in front of one ram_core.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic          win;
  logic [DW-1:0] ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= REQ_B;
      owner_q     <= REQ_A;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    win         = REQ_A;
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // On a tie the requester that did not win last time goes first.
          if (a_req && b_req) begin
            win = (last_q == REQ_A) ? REQ_B : REQ_A;
          end else begin
            win = a_req ? REQ_A : REQ_B;
          end
          owner_d     = win;
          last_d      = win;
          cmd_we_d    = (win == REQ_A) ? a_we : b_we;
          cmd_addr_d  = (win == REQ_A) ? a_addr : b_addr;
          cmd_wdata_d = (win == REQ_A) ? a_wdata : b_wdata;
          state_d     = BUSY;
        end
      end
      BUSY:    state_d = cmd_we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ram_core #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   ((state_q == BUSY) && cmd_we_q),
    .addr (cmd_addr_q),
    .wdata(cmd_wdata_q),
    .q    (ram_q)
  );

  // BUSY lasts exactly one cycle, so the grant pulse is decoded from it.
  assign busy     = (state_q != IDLE);
  assign a_gnt    = (state_q == BUSY) && (owner_q == REQ_A);
  assign b_gnt    = (state_q == BUSY) && (owner_q == REQ_B);
  assign a_rvalid = (state_q == RESP) && (owner_q == REQ_A);
  assign b_rvalid = (state_q == RESP) && (owner_q == REQ_B);
  assign a_rdata  = a_rvalid ? ram_q : '0;
  assign b_rdata  = b_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed plan steps followed by randomized traffic.
module tb_ram_arbiter;

  typedef struct {
    logic       v;
    logic       we;
    logic [4:0] addr;
    logic [3:0] wd;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [3:0] a_rdata, b_rdata;

  int compared = 0;
  int mismatched = 0;

  // Reference model: memory image, written-flags, last winner (0 = A, 1 = B).
  logic [3:0] mem [32];
  bit         wr [32];
  int         last;
  int         prev_win;
  int         win_log [$];
  cmd_t       pa, pb;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(5), .DW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_gnt   (a_gnt),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_gnt   (b_gnt),
    .b_rvalid(b_rvalid),
    .b_rdata (b_rdata),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".gnt"}, {30'd0, a_gnt, b_gnt}, 32'd0);
    chk({tag, ".rvalid"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk({tag, ".rdata"}, {24'd0, a_rdata, b_rdata}, 32'd0);
  endtask

  // Present pending commands, then check one full transaction against the model.
  task automatic run_txn(input string tag, output int winner);
    cmd_t c;
    a_req = pa.v; a_we = pa.we; a_addr = pa.addr; a_wdata = pa.wd;
    b_req = pb.v; b_we = pb.we; b_addr = pb.addr; b_wdata = pb.wd;
    @(posedge clk); #1;
    if (pa.v && pb.v) winner = (last == 0) ? 1 : 0;
    else              winner = pa.v ? 0 : 1;
    chk({tag, ".gnt"}, {30'd0, a_gnt, b_gnt}, (winner == 0) ? 32'd2 : 32'd1);
    chk({tag, ".busy1"}, {31'd0, busy}, 32'd1);
    chk({tag, ".rv1"}, {24'd0, a_rvalid, b_rvalid, a_rdata, b_rdata}, 32'd0);
    last = winner;
    win_log.push_back(winner);
    if (winner == 0) begin c = pa; pa.v = 1'b0; a_req = 1'b0; end
    else             begin c = pb; pb.v = 1'b0; b_req = 1'b0; end
    @(posedge clk); #1;
    if (c.we) begin
      mem[c.addr] = c.wd;
      wr[c.addr] = 1'b1;
      chk_quiet({tag, ".wdone"});
    end else begin
      chk({tag, ".rvalid"}, {30'd0, a_rvalid, b_rvalid}, (winner == 0) ? 32'd2 : 32'd1);
      chk({tag, ".rdata"}, {24'd0, a_rdata, b_rdata},
          (winner == 0) ? {24'd0, mem[c.addr], 4'd0} : {28'd0, mem[c.addr]});
      chk({tag, ".busy2"}, {31'd0, busy}, 32'd1);
      chk({tag, ".gnt2"}, {30'd0, a_gnt, b_gnt}, 32'd0);
      @(posedge clk); #1;
      chk_quiet({tag, ".rdone"});
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [4:0] addr, input logic [3:0] wd);
    cmd_t c;
    c.v = 1'b1; c.we = we; c.addr = addr; c.wd = wd;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c = mk(1'(($urandom_range(0, 2) == 0)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    if (!wr[c.addr]) c.we = 1'b1;  // never read a word the model has not written
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gnts [$];
    for (int i = 0; i < 32; i++) wr[i] = 1'b0;
    pa = '{default: '0};
    pb = '{default: '0};
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    rst = 1'b1;
    last = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_quiet("idle_after_reset");

    // Single write then read, A only.
    pa = mk(1'b1, 5'd1, 4'h3);
    run_txn("a_wr1", w);
    pa = mk(1'b0, 5'd1, 4'h0);
    run_txn("a_rd1", w);

    // Simultaneous writes: A first after reset pointer, then B.
    rst = 1'b1; #1; rst = 1'b0; last = 1;
    pa = mk(1'b1, 5'd2, 4'h5);
    pb = mk(1'b1, 5'd3, 4'hA);
    run_txn("tie_wr0", w);
    chk("tie_first_is_a", w, 0);
    run_txn("tie_wr1", w);
    chk("tie_second_is_b", w, 1);
    pa = mk(1'b0, 5'd2, 4'h0);
    run_txn("rd_a2", w);
    pb = mk(1'b0, 5'd3, 4'h0);
    run_txn("rd_b3", w);

    // Sustained read contention: strict alternation.
    prev_win = last;
    for (int i = 0; i < 6; i++) begin
      if (!pa.v) pa = mk(1'b0, 5'd2, 4'h0);
      if (!pb.v) pb = mk(1'b0, 5'd3, 4'h0);
      run_txn("contend", w);
      chk("alternate", w, (prev_win == 0) ? 1 : 0);
      prev_win = w;
    end
    pa.v = 1'b0; pb.v = 1'b0; a_req = 0; b_req = 0;
    // Drain the loser's last command still pending at the loop end is dropped here.
    @(posedge clk); #1;
    if (busy) begin
      repeat (3) @(posedge clk);
      #1;
    end
    last = prev_win;
    // A stray grant above would have changed the pointer; resync by reset.
    rst = 1'b1; #1; rst = 1'b0; last = 1;

    // Cross-requester same address, top boundary.
    pb = mk(1'b1, 5'd31, 4'hF);
    run_txn("b_wr31", w);
    pa = mk(1'b0, 5'd31, 4'h0);
    run_txn("a_rd31", w);

    // Reset in BUSY of a read.
    pa = mk(1'b0, 5'd31, 4'h0);
    a_req = 1; a_we = 0; a_addr = 5'd31;
    @(posedge clk); #1;
    chk("rst_mid.gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    a_req = 0; pa.v = 1'b0;
    rst = 1'b1; #1;
    chk_quiet("rst_mid.immediate");
    @(posedge clk); #1;
    chk_quiet("rst_mid.held");
    @(negedge clk);
    rst = 1'b0;
    last = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_quiet("rst_mid.no_rvalid");
    end
    pa = mk(1'b1, 5'd4, 4'h6);
    pb = mk(1'b1, 5'd5, 4'h9);
    run_txn("rst_tie0", w);
    chk("rst_tie_a_first", w, 0);
    run_txn("rst_tie1", w);

    // A read req held for 5 sampling edges: grants at edges 0 and 3 only.
    a_req = 1; a_we = 0; a_addr = 5'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (a_gnt) gnts.push_back(i);
      if (a_rvalid) chk("held.rdata", {28'd0, a_rdata}, {28'd0, mem[4]});
    end
    a_req = 0;
    for (int i = 5; i < 9; i++) begin
      @(posedge clk); #1;
      if (a_gnt) gnts.push_back(i);
    end
    chk("held.gnt_count", gnts.size(), 2);
    if (gnts.size() == 2) chk("held.gnt_spacing", gnts[1] - gnts[0], 3);
    chk_quiet("held.idle");
    last = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      if (!pa.v && $urandom_range(0, 1) == 1) pa = rnd_cmd();
      if (!pb.v && $urandom_range(0, 1) == 1) pb = rnd_cmd();
      if (!pa.v && !pb.v) pa = rnd_cmd();
      run_txn("rand", w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
